exc_ctrl: RTL
=============

# exc_ctrl

Exception and interrupt sequencer for the MIPS32 pipeline. It sits between the MEM stage, the CP0 register file and the PC/pipeline-register stall and flush network. It accepts a committed exception code from MEM, or detects a pending enabled interrupt from CP0 Status/Cause. It then waits for any outstanding data-bus transaction, commits the exception to CP0 for exactly one cycle, and flushes the pipeline with a redirect PC (the exception vector, or EPC for eret). Outside exception handling it merges the ID and EX stall requests into the 6-bit stall vector.

## Interface
- EXC_VECTOR, 32'h0000_0020, redirect target for every exception except eret.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (rst==0 resets).
- excepttype_i  in  32  MEM-stage exception code: 0 = none, 8 syscall, 9 break, a invalid inst, c overflow, d trap, e eret.
- current_inst_addr_i  in  32  PC of the MEM-stage instruction.
- is_in_delayslot_i  in  1  MEM-stage instruction is in a delay slot.
- inst_valid_i  in  1  MEM stage holds a real instruction, not a bubble.
- cp0_status_i  in  32  CP0 Status, forwarded value (IE = bit 0, EXL = bit 1, IM = bits 15:8).
- cp0_cause_i  in  32  CP0 Cause, forwarded value (IP = bits 15:8).
- cp0_epc_i  in  32  CP0 EPC, forwarded value.
- mem_busy_i  in  1  data-bus transaction outstanding.
- stallreq_id_i  in  1  stall request from ID.
- stallreq_ex_i  in  1  stall request from EX.
- stall_o  out  6  stall vector: bit 0 = PC, up to bit 5 = WB.
- flush_o  out  1  flush all pipeline registers.
- new_pc_o  out  32  redirect target; valid only while flush_o=1.
- excepttype_o  out  32  one-cycle commit code to CP0; 0 otherwise.
- exc_pc_o  out  32  latched faulting PC to CP0.
- exc_bd_o  out  1  latched delay-slot flag to CP0.

## Operation
- **States:** IDLE, DRAIN, FLUSH, SETTLE. Reset forces IDLE.
- **Reset values:**
  - flush_o, excepttype_o, exc_pc_o, exc_bd_o, new_pc_o all 0.
  - Latched code/PC/BD registers 0.
  - stall_o = 0, because no requests are present in IDLE.
- **Interrupt pending (irq):**
  - (cause_i[15:8] & status_i[15:8]) != 0
  - && status_i[0]==1
  - && status_i[1]==0
  - && inst_valid_i.
- **Event in IDLE:**
  - An event is irq or excepttype_i != 0.
  - Interrupt priority: irq wins and the latched code is 32'h1, even if excepttype_i != 0.
  - Otherwise the latched code is excepttype_i.
  - current_inst_addr_i and is_in_delayslot_i are latched in the same cycle.
  - Next state is DRAIN if mem_busy_i=1, else FLUSH.
- **DRAIN:** hold until mem_busy_i=0, then go to FLUSH. No timeout.
- **FLUSH** (exactly one cycle, then SETTLE):
  - flush_o = 1.
  - excepttype_o = latched code.
  - exc_pc_o / exc_bd_o = latched values.
  - new_pc_o = cp0_epc_i (sampled this cycle) if the code is 32'he, else EXC_VECTOR.
  - Any nonzero code other than 0xe redirects to EXC_VECTOR.
- **SETTLE:** one cycle so the CP0 EXL update is visible before new fetches are judged; then IDLE.
- **stall_o** (combinational from state and inputs):
  - IDLE with event: 6'b111111.
  - IDLE without event: 6'b001111 if stallreq_ex_i; else 6'b000111 if stallreq_id_i; else 0. EX has priority over ID.
  - DRAIN and SETTLE: 6'b111111.
  - FLUSH: 6'b000000.
- **Events outside IDLE:** excepttype_i and irq are ignored in DRAIN, FLUSH and SETTLE. The offending instructions are flushed.
- **Reset mid-sequence:** return to IDLE immediately. No flush or commit pulse is emitted.

## Timing
- **Event without drain:** event detected in IDLE in cycle N with mem_busy_i=0.
  - FLUSH in N+1: flush_o, excepttype_o and new_pc_o valid.
  - SETTLE in N+2.
  - IDLE in N+3.
- **Event with drain:** mem_busy_i high for k cycles starting at N.
  - DRAIN covers N+1 .. N+k.
  - FLUSH in N+k+1.
- **Pulse widths:** flush_o and excepttype_o are each exactly one cycle per accepted event.
- **Back-to-back events:** minimum spacing between accepted events is 3 cycles.

## Test plan
- **Syscall, no drain:** excepttype_i=8, pc=0x100, bd=0, mem_busy=0 at N -> at N+1: flush_o=1, excepttype_o=8, exc_pc_o=0x100, new_pc_o=0x20; stall_o=0x3F at N and N+2; IDLE at N+3.
- **eret:** excepttype_i=e, cp0_epc_i=0x1234 -> flush pulse with new_pc_o=0x1234, excepttype_o=0xe.
- **Interrupt priority:** status=0x0000_0401, cause IP2 set, inst_valid=1, excepttype_i=0xa in the same cycle -> excepttype_o=1. Repeat with EXL=1 or IE=0 -> no event.
- **Drain:** overflow (0xc) with mem_busy_i high 3 cycles -> stall_o=0x3F throughout; flush_o only in the cycle after mem_busy_i falls; exc_bd_o equals the latched delay-slot flag.
- **Stall merging in IDLE:** both requests -> 0x0F; ID request only -> 0x07; none -> 0. An exception arriving during SETTLE is ignored.
- **Reset in DRAIN:** assert rst=0 asynchronously -> all outputs 0 immediately; no flush pulse after release.

Source files
------------

// File: rtl/exc_ctrl.sv
// ----------------------------------------------------------------------------
// exc_ctrl -- exception / interrupt sequencer for the MIPS32 pipeline.
//
// Accepts a committed exception code from MEM, or detects a pending enabled
// interrupt from the forwarded CP0 Status/Cause values. It waits for any
// outstanding data-bus transaction and then commits the exception to CP0 for
// exactly one cycle. In that same cycle it flushes the pipeline and supplies
// the redirect PC: the exception vector, or EPC for eret. One settle cycle
// follows. Outside exception handling it merges the ID/EX stall requests.
//
// Ports
//   clk                 system clock, rising edge
//   rst                 asynchronous reset, active low
//   excepttype_i        MEM-stage exception code (0 = none, 0xe = eret)
//   current_inst_addr_i PC of the MEM-stage instruction
//   is_in_delayslot_i   MEM-stage instruction sits in a delay slot
//   inst_valid_i        MEM stage holds a real instruction (not a bubble)
//   cp0_status_i        CP0 Status (IE = [0], EXL = [1], IM = [15:8])
//   cp0_cause_i         CP0 Cause (IP = [15:8])
//   cp0_epc_i           CP0 EPC, used as the eret target
//   mem_busy_i          data-bus transaction outstanding
//   stallreq_id_i       stall request from ID
//   stallreq_ex_i       stall request from EX
//   stall_o             stall vector, bit 0 = PC ... bit 5 = WB
//   flush_o             flush all pipeline registers (one cycle)
//   new_pc_o            redirect target, meaningful only while flush_o = 1
//   excepttype_o        one-cycle commit code to CP0, 0 otherwise
//   exc_pc_o            latched faulting PC
//   exc_bd_o            latched delay-slot flag
// ----------------------------------------------------------------------------
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    input  logic        inst_valid_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        mem_busy_i,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic [31:0] excepttype_o,
    output logic [31:0] exc_pc_o,
    output logic        exc_bd_o
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;
    localparam logic [1:0] S_SETTLE = 2'd3;

    localparam logic [31:0] CODE_IRQ  = 32'h0000_0001;
    localparam logic [31:0] CODE_ERET = 32'h0000_000e;

    localparam logic [5:0] STALL_ALL  = 6'b111111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    // Everything CP0 needs about the accepted event, captured in one shot.
    typedef struct packed {
        logic [31:0] code;
        logic [31:0] pc;
        logic        bd;
    } exc_rec_t;

    logic [1:0] state_q, state_d;
    exc_rec_t   rec_q, rec_d;

    logic irq;
    logic exc_req;
    logic event_det;

    // Only the IE/EXL/IM fields of Status and the IP field of Cause matter here.
    logic unused_cp0_bits;
    assign unused_cp0_bits = ^{cp0_status_i[31:16], cp0_status_i[7:2],
                               cp0_cause_i[31:16], cp0_cause_i[7:0]};

    // ------------------------------------------------------------------------
    // Event detection
    // ------------------------------------------------------------------------
    // An interrupt is taken only if it is unmasked, interrupts are globally
    // enabled, we are not already at exception level, and a real instruction
    // is in MEM that the EPC can point to.
    always_comb begin
        irq = (|(cp0_cause_i[15:8] & cp0_status_i[15:8]))
              && cp0_status_i[0]
              && !cp0_status_i[1]
              && inst_valid_i;
    end

    assign exc_req = |excepttype_i;

    // Events are only heard in IDLE. Anything arriving while a sequence runs
    // belongs to an instruction that the coming flush will kill anyway.
    assign event_det = (state_q == S_IDLE) && (irq || exc_req);

    // ------------------------------------------------------------------------
    // Next state / capture
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        rec_d   = rec_q;
        case (state_q)
            S_IDLE: begin
                if (event_det) begin
                    // Interrupt wins over a synchronous exception in the same cycle.
                    rec_d.code = irq ? CODE_IRQ : excepttype_i;
                    rec_d.pc   = current_inst_addr_i;
                    rec_d.bd   = is_in_delayslot_i;
                    state_d    = mem_busy_i ? S_DRAIN : S_FLUSH;
                end
            end
            S_DRAIN: begin
                // Wait for the bus unconditionally; the memory side must finish.
                if (!mem_busy_i) state_d = S_FLUSH;
            end
            S_FLUSH:  state_d = S_SETTLE;
            // Gives CP0 a cycle to make EXL visible before IDLE judges new work.
            S_SETTLE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            rec_q   <= '0;
        end else begin
            state_q <= state_d;
            rec_q   <= rec_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Commit, flush and redirect are all decoded from the FLUSH state, so each
    // is exactly one cycle wide and vanishes as soon as reset asserts.
    assign flush_o      = (state_q == S_FLUSH);
    assign excepttype_o = flush_o ? rec_q.code : 32'h0;
    assign exc_pc_o     = rec_q.pc;
    assign exc_bd_o     = rec_q.bd;

    // EPC is taken live in the flush cycle so a CP0 write that lands just
    // before the flush is honoured.
    always_comb begin
        new_pc_o = 32'h0;
        if (flush_o) begin
            new_pc_o = (rec_q.code == CODE_ERET) ? cp0_epc_i : EXC_VECTOR;
        end
    end

    // Freeze the whole pipe while an event is being sequenced; release it in
    // the flush cycle so the redirect PC and the cleared registers load.
    always_comb begin
        stall_o = STALL_NONE;
        if (rst) begin
            case (state_q)
                S_IDLE: begin
                    if (event_det)          stall_o = STALL_ALL;
                    else if (stallreq_ex_i) stall_o = STALL_EX;
                    else if (stallreq_id_i) stall_o = STALL_ID;
                    else                    stall_o = STALL_NONE;
                end
                S_DRAIN:  stall_o = STALL_ALL;
                S_FLUSH:  stall_o = STALL_NONE;
                S_SETTLE: stall_o = STALL_ALL;
                default:  stall_o = STALL_NONE;
            endcase
        end
    end

endmodule
